// File: rtl/risc_pkg.sv
// Shared VeriRisc definitions: opcode encoding used by the datapath and sequence controller.
package risc_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

endpackage

// File: rtl/risc_alu.sv
// Combinational VeriRisc ALU: result selected by the IR opcode from ACC and memory read data.
module risc_alu
    import risc_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  opcode_t             opcode,
    input  logic [DWIDTH-1:0]   acc,
    input  logic [DWIDTH-1:0]   data,
    output logic [DWIDTH-1:0]   result
);

    always_comb begin
        result = acc;
        case (opcode)
            OP_ADD:  result = acc + data;   // carry discarded by width
            OP_AND:  result = acc & data;
            OP_XOR:  result = acc ^ data;
            OP_LDA:  result = data;
            default: result = acc;          // HLT/SKZ/STO/JMP pass ACC through
        endcase
    end

endmodule

// File: rtl/risc_datapath.sv
// VeriRisc datapath: IR, ACC, PC and halt flag, plus ALU, address mux and data-bus driver.
module risc_datapath
    import risc_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              ld_ir,
    input  logic              ld_acc,
    input  logic              ld_pc,
    input  logic              inc_pc,
    input  logic              sel,
    input  logic              data_e,
    input  logic              halt,
    output logic [OPW-1:0]    opcode,
    output logic              zero,
    output logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_oe,
    output logic              halted
);

    logic [DWIDTH-1:0] ir, acc, alu_res;
    logic [AWIDTH-1:0] pc;
    opcode_t           op;

    assign op = opcode_t'(ir[DWIDTH-1 -: OPW]);

    risc_alu #(.DWIDTH(DWIDTH)) u_alu (
        .opcode (op),
        .acc    (acc),
        .data   (data_in),
        .result (alu_res)
    );

    // ACC samples the ALU driven by the pre-edge IR, so ld_ir+ld_acc together is well defined.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir     <= '0;
            acc    <= '0;
            pc     <= '0;
            halted <= 1'b0;
        end else begin
            if (ld_ir)  ir  <= data_in;
            if (ld_acc) acc <= alu_res;
            if (halt && op == OP_HLT) halted <= 1'b1;
            if (!halted) begin
                if (ld_pc)       pc <= ir[AWIDTH-1:0];
                else if (inc_pc) pc <= pc + 1'b1;
            end
        end
    end

    assign opcode   = ir[DWIDTH-1 -: OPW];
    assign zero     = (acc == '0);
    assign addr     = sel ? pc : ir[AWIDTH-1:0];
    assign data_out = acc;
    assign data_oe  = data_e;

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath: fetch, ALU ops, PC wrap/priority, store path, reset and halt.
module tb_risc_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       ld_ir, ld_acc, ld_pc, inc_pc, sel, data_e, halt;
    logic [2:0] opcode;
    logic       zero;
    logic [4:0] addr;
    logic [7:0] data_out;
    logic       data_oe;
    logic       halted;

    int checks = 0;
    int errors = 0;

    risc_datapath #(.DWIDTH(8), .AWIDTH(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .ld_ir    (ld_ir),
        .ld_acc   (ld_acc),
        .ld_pc    (ld_pc),
        .inc_pc   (inc_pc),
        .sel      (sel),
        .data_e   (data_e),
        .halt     (halt),
        .opcode   (opcode),
        .zero     (zero),
        .addr     (addr),
        .data_out (data_out),
        .data_oe  (data_oe),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, sample 1ns later, then drop all single-cycle strobes.
    task automatic step();
        @(posedge clk);
        #1;
        ld_ir = 0; ld_acc = 0; ld_pc = 0; inc_pc = 0; halt = 0;
    endtask

    initial begin
        rst = 0; data_in = 0; ld_ir = 0; ld_acc = 0; ld_pc = 0; inc_pc = 0;
        sel = 1; data_e = 0; halt = 0;
        #12;
        chk("rst_opcode", opcode, 0);
        chk("rst_zero", zero, 1);
        chk("rst_addr", addr, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_data_oe", data_oe, 0);
        rst = 1;

        // Fetch and PC increment
        data_in = 8'hA5; ld_ir = 1; step();
        chk("fetch_opcode", opcode, 3'b101);
        inc_pc = 1; step();
        inc_pc = 1; step();
        inc_pc = 1; step();
        chk("pc_inc3", addr, 3);
        sel = 0; #1;
        chk("addr_ir_operand", addr, 5'h05);
        sel = 1;

        // ALU
        data_in = 8'hF0; ld_acc = 1; step();
        chk("lda_f0", data_out, 8'hF0);
        data_in = 8'h40; ld_ir = 1; step();
        data_in = 8'h20; ld_acc = 1; step();
        chk("add_wrap", data_out, 8'h10);
        chk("add_zero", zero, 0);
        data_in = 8'h80; ld_ir = 1; step();
        data_in = 8'h10; ld_acc = 1; step();
        chk("xor_acc", data_out, 8'h00);
        chk("xor_zero", zero, 1);
        data_in = 8'hA0; ld_ir = 1; step();
        data_in = 8'hFF; ld_acc = 1; step();
        data_in = 8'h60; ld_ir = 1; step();
        data_in = 8'h0F; ld_acc = 1; step();
        chk("and_acc", data_out, 8'h0F);
        // ld_ir with ld_acc: ACC uses the old AND opcode, IR takes the new word
        data_in = 8'hA3; ld_ir = 1; ld_acc = 1; step();
        chk("iracc_acc", data_out, 8'h03);
        chk("iracc_opcode", opcode, 3'b101);
        data_in = 8'h55; #1;
        chk("zero_indep_data", zero, 0);

        // PC wrap and ld_pc priority
        data_in = 8'hFF; ld_ir = 1; step();
        ld_pc = 1; step();
        chk("pc_load31", addr, 31);
        inc_pc = 1; step();
        chk("pc_wrap", addr, 0);
        data_in = 8'hEC; ld_ir = 1; step();
        ld_pc = 1; inc_pc = 1; step();
        chk("pc_ld_priority", addr, 12);

        // Store path
        data_in = 8'hA0; ld_ir = 1; step();
        data_in = 8'h5A; ld_acc = 1; step();
        data_e = 1; #1;
        chk("sto_oe_on", data_oe, 1);
        chk("sto_data", data_out, 8'h5A);
        data_e = 0; #1;
        chk("sto_oe_off", data_oe, 0);

        // Asynchronous reset mid-instruction with ACC=3C, PC=9
        data_in = 8'hA9; ld_ir = 1; step();
        ld_pc = 1; step();
        data_in = 8'h3C; ld_acc = 1; step();
        chk("pre_rst_pc", addr, 9);
        chk("pre_rst_acc", data_out, 8'h3C);
        #2;
        ld_acc = 1; inc_pc = 1; rst = 0; #1;
        chk("mid_rst_opcode", opcode, 0);
        chk("mid_rst_zero", zero, 1);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_acc", data_out, 0);
        ld_acc = 0; inc_pc = 0;
        #3; rst = 1;

        // Halt
        data_in = 8'hA0; ld_ir = 1; step();
        inc_pc = 1; step();
        inc_pc = 1; step();
        halt = 1; step();
        chk("no_halt_non_hlt", halted, 0);
        data_in = 8'h05; ld_ir = 1; step();
        halt = 1; step();
        chk("halted_set", halted, 1);
        chk("halt_pc", addr, 2);
        inc_pc = 1; step();
        chk("halt_inc_ignored", addr, 2);
        ld_pc = 1; step();
        chk("halt_ld_ignored", addr, 2);
        data_in = 8'h40; ld_ir = 1; step();
        chk("halt_ir_updates", opcode, 3'b010);
        chk("halted_sticky", halted, 1);
        #2; rst = 0; #1;
        chk("halt_cleared_rst", halted, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc_datapath.md
# risc_datapath

Datapath stage of the VeriRisc CPU, sitting directly downstream of the sequence controller: it consumes the controller's load, increment, select and enable strobes, and returns the `opcode` and `zero` inputs the controller sequences on. It holds the instruction register (IR), accumulator (ACC), program counter (PC), ALU, address multiplexer and data-bus output driver. Memory and the controller are external.

## Interface
- `DWIDTH`, 8: data, IR and ACC width; IR = {opcode[2:0], operand address[AWIDTH-1:0]}; requires DWIDTH = AWIDTH + 3.
- `AWIDTH`, 5: PC and address width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data_in`  in  DWIDTH  memory read data; valid whenever `rd` is high.
- `ld_ir`  in  1  load IR from `data_in`.
- `ld_acc`  in  1  load ACC from ALU result.
- `ld_pc`  in  1  load PC from IR operand field.
- `inc_pc`  in  1  increment PC.
- `sel`  in  1  address select: 1 = PC, 0 = IR operand.
- `data_e`  in  1  enable ACC onto data bus.
- `halt`  in  1  controller halt strobe.
- `opcode`  out  3  IR[DWIDTH-1:DWIDTH-3], to controller.
- `zero`  out  1  high when ACC == 0, to controller.
- `addr`  out  AWIDTH  memory address.
- `data_out`  out  DWIDTH  ACC value for memory writes.
- `data_oe`  out  1  bus-drive enable for `data_out`.
- `halted`  out  1  sticky halt indicator.

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALU result, combinational from IR opcode, ACC and `data_in`:
  - ADD: ACC + data_in, mod 2^DWIDTH, carry discarded.
  - AND: ACC & data_in.
  - XOR: ACC ^ data_in.
  - LDA: data_in.
  - HLT/SKZ/STO/JMP: ACC (pass-through).
- IR: on `ld_ir`, IR <= data_in; otherwise holds.
- ACC: on `ld_acc`, ACC <= ALU result; otherwise holds.
- PC priority, highest first:
  - `halted` set: PC holds; `ld_pc` and `inc_pc` are ignored.
  - `ld_pc`: PC <= IR[AWIDTH-1:0].
  - `inc_pc`: PC <= PC + 1, wrapping from 2^AWIDTH-1 to 0.
  - Neither asserted: PC holds.
- `addr` = sel ? PC : IR[AWIDTH-1:0], combinational.
- `data_out` = ACC at all times; `data_oe` = `data_e`, combinational.
- `zero` = (ACC == 0), combinational from the ACC register; it never depends on `data_in`.
- `halted`: set on the rising edge where `halt` = 1 and IR opcode = HLT; cleared only by reset.
- IR, ACC and `halted` continue to update per their rules while `halted` is set; only PC is frozen.

## Timing
- Reset (`rst` low, asynchronous):
  - Registers: IR=0, ACC=0, PC=0, halted=0.
  - Outputs therefore: opcode=0, zero=1, addr=0 (the PC value, since IR operand is also 0), data_out=0; `data_oe` follows `data_e`.
- Reset release is sampled synchronously; the first state update occurs on the first rising edge with `rst` high.
- Register latency: a strobe high at edge N takes effect on IR/ACC/PC at edge N; `opcode`, `zero` and `addr` reflect the new value after that edge.
- `ld_ir` and `ld_acc` asserted together: IR loads `data_in`; ACC uses the ALU result computed from the pre-edge IR opcode.
- Reset asserted mid-instruction: all state clears immediately regardless of which strobes are active.

## Structure
- Shared package `risc_pkg`: opcode enum/localparams (HLT..JMP) and the opcode field width, 3. The sequence controller uses the same package.
- One sub-module, `risc_alu`: purely combinational (opcode, acc, data) -> result, in its own file.
- The top level holds the IR, ACC, PC and halted registers plus the address/output muxing.

## Test plan
- Reset: drive `rst`=0 mid-run with ACC=8'h3C, PC=5'd9 -> IR/ACC/PC clear immediately with no clock edge; opcode=0, zero=1, addr=0.
- Fetch/PC: data_in=8'hA5 with `ld_ir`, then 3×`inc_pc` from PC=0 -> opcode=3'b101, PC=3, `sel`=0 gives addr=5'h05.
- ALU:
  - LDA data_in=8'hF0, then ADD 8'h20 -> ACC=8'h10 (carry dropped), zero=0.
  - Then XOR 8'h10 -> ACC=0, zero=1.
  - Then AND against ACC=8'hFF with data 8'h0F -> 8'h0F.
- PC wrap and priority:
  - PC=31 with `inc_pc` -> PC=0.
  - `ld_pc` and `inc_pc` together with IR operand 5'd12 -> PC=12.
- Store path: ACC=8'h5A, `data_e`=1 -> data_oe=1, data_out=8'h5A; `data_e`=0 -> data_oe=0.
- Halt: IR opcode=HLT, `halt`=1 for one cycle -> halted=1; subsequent `inc_pc`/`ld_pc` leave PC unchanged; halted stays 1 until `rst` low.
